// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : Shared state encoding for the bit-serial add/subtract units.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

    // Encodings are shared with the serial adder variant; keep them fixed.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// ============================================================================
// Module      : serial_subtractor_full_subtractor
// Description : One-bit full subtractor (a - b - bin) built from two
//               half-subtractor stages and an OR, mirroring the adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_d1;
    logic w_b1;
    logic w_b2;

    assign w_d1 = a ^ b;
    assign w_b1 = ~a & b;
    assign d    = w_d1 ^ bin;
    assign w_b2 = ~w_d1 & bin;
    assign bout = w_b1 | w_b2;

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor
//               cell and a registered borrow; start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-2:0]   r_res_sr;
    logic               r_borrow;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow_out;
    logic               r_overflow;

    logic               w_d;
    logic               w_bout;
    logic               w_last;
    logic [WIDTH-1:0]   w_res;
    logic               w_busy;
    logic               w_done;

    serial_subtractor_full_subtractor u_fsub (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // The final difference bit goes straight to diff, so the shift register
    // only has to hold the WIDTH-1 bits produced before it.
    assign w_res  = {w_d, r_res_sr};
    assign w_last = (r_cnt == c_last_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_res_sr     <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res[WIDTH-1:1];
                    r_borrow <= w_bout;
                    r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        // Operand MSBs sit in bit 0 of the shift registers here.
                        r_diff       <= w_res;
                        r_borrow_out <= w_bout;
                        r_overflow   <= (r_a_sr[0] != r_b_sr[0]) && (w_d != r_a_sr[0]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = w_busy;
    assign done       = w_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int           checks;
    int           errors;

    // Model of the currently held result registers.
    logic [W-1:0] m_diff;
    logic         m_bo;
    logic         m_ov;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] d, output logic bo, output logic ov);
        int sx;
        int sy;
        int sd;
        d  = W'((int'(x) - int'(y) + (2 ** W)) % (2 ** W));
        bo = (x < y);
        sx = (int'(x) >= 2 ** (W - 1)) ? int'(x) - 2 ** W : int'(x);
        sy = (int'(y) >= 2 ** (W - 1)) ? int'(y) - 2 ** W : int'(y);
        sd = sx - sy;
        ov = (sd > 2 ** (W - 1) - 1) || (sd < -(2 ** (W - 1)));
    endfunction

    // One operation from an idle DUT; poke_x (1..W+1) asserts an ignored
    // start with all-ones operands in that cycle.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input int poke_x, input int poke_y);
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        ref_sub(ia, ib, ed, eb, eo);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        for (int c = 1; c <= W; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++;
                $display("FAIL shift_handshake a=%h b=%h cyc=%0d busy/done=%b expected 10", ia, ib, c, {busy, done});
            end
            checks++;
            if ({diff, borrow_out, overflow} !== {m_diff, m_bo, m_ov}) begin
                errors++;
                $display("FAIL shift_hold a=%h b=%h cyc=%0d got %h/%b/%b expected %h/%b/%b",
                         ia, ib, c, diff, borrow_out, overflow, m_diff, m_bo, m_ov);
            end
            start = (c == poke_x) || (c == poke_y);
            a     = start ? '1 : W'($urandom);
            b     = start ? '1 : W'($urandom);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b11) begin
            errors++;
            $display("FAIL done_pulse a=%h b=%h busy/done=%b expected 11", ia, ib, {busy, done});
        end
        checks++;
        if ({diff, borrow_out, overflow} !== {ed, eb, eo}) begin
            errors++;
            $display("FAIL result a=%h b=%h got %h/%b/%b expected %h/%b/%b",
                     ia, ib, diff, borrow_out, overflow, ed, eb, eo);
        end
        m_diff = ed;
        m_bo   = eb;
        m_ov   = eo;
        start  = (W + 1 == poke_x) || (W + 1 == poke_y);
        a      = '1;
        b      = '1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL back_to_idle a=%h b=%h busy/done=%b expected 00", ia, ib, {busy, done});
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, diff, borrow_out, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b diff=%h bo=%b ov=%b expected all 0",
                     busy, done, diff, borrow_out, overflow);
        end
        start  = 1'b0;
        m_diff = '0;
        m_bo   = 1'b0;
        m_ov   = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset busy/done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[4] = '{8'h05, 8'h03, 8'h80, 8'h7F};
        logic [W-1:0] tb[4] = '{8'h03, 8'h05, 8'h01, 8'hFF};
        logic [W-1:0] td[4] = '{8'h02, 8'hFE, 8'h7F, 8'h80};
        logic [1:0]   tf[4] = '{2'b00, 2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], 0, 0);
            checks++;
            if ({diff, borrow_out, overflow} !== {td[i], tf[i]}) begin
                errors++;
                $display("FAIL directed_%0d got %h/%b/%b expected %h/%b", i, diff, borrow_out, overflow, td[i], tf[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        run_op(8'h10, 8'h01, 3, W + 1);
        checks++;
        if (diff !== 8'h0F) begin
            errors++;
            $display("FAIL ignored_start_diff got %h expected 0f", diff);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL ignored_start_taken cyc=%0d busy/done=%b expected 00", i, {busy, done});
            end
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, diff, borrow_out, overflow} !== '0) begin
            errors++;
            $display("FAIL abort_outputs busy=%b done=%b diff=%h bo=%b ov=%b expected all 0",
                     busy, done, diff, borrow_out, overflow);
        end
        m_diff = '0;
        m_bo   = 1'b0;
        m_ov   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL abort_no_done cyc=%0d busy/done=%b expected 00", i, {busy, done});
            end
        end
        run_op(8'h00, 8'h00, 0, 0);
        checks++;
        if ({diff, borrow_out} !== 9'h000) begin
            errors++;
            $display("FAIL after_abort got %h/%b expected 00/0", diff, borrow_out);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] corner[4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        for (int i = 0; i < 1000; i++) begin
            ra = (i % 4 == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rb = (i % 4 == 1) ? corner[$urandom_range(0, 3)] : W'($urandom);
            run_op(ra, rb, int'($urandom_range(0, W + 1)), int'($urandom_range(0, W + 1)));
        end
    endtask

    // start held high: a new operation every W+2 cycles.
    task automatic test_back_to_back();
        localparam int P = W + 2;
        logic [W-1:0] qa[5];
        logic [W-1:0] qb[5];
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        for (int k = 0; k < 5; k++) begin
            qa[k] = W'($urandom);
            qb[k] = W'($urandom);
        end
        @(negedge clk);
        for (int c = 0; c < 5 * P; c++) begin
            checks++;
            if ({busy, done} !== {(c % P) != 0, (c % P) == P - 1}) begin
                errors++;
                $display("FAIL b2b_handshake cyc=%0d busy/done=%b expected %b%b",
                         c, {busy, done}, (c % P) != 0, (c % P) == P - 1);
            end
            if (c % P == P - 1) begin
                ref_sub(qa[c / P], qb[c / P], ed, eb, eo);
                checks++;
                if ({diff, borrow_out, overflow} !== {ed, eb, eo}) begin
                    errors++;
                    $display("FAIL b2b_result op=%0d got %h/%b/%b expected %h/%b/%b",
                             c / P, diff, borrow_out, overflow, ed, eb, eo);
                end
                m_diff = ed;
                m_bo   = eb;
                m_ov   = eo;
            end
            start = 1'b1;
            a     = (c % P == 0) ? qa[c / P] : W'($urandom);
            b     = (c % P == 0) ? qb[c / P] : W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
